// File: rtl/manch_pkg.sv
// manch_pkg: shared Manchester encoder/receiver types and half-bit timing helpers
package manch_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, GAP} state_e;
  function automatic int halfbit_clks(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction
  function automatic int halfbit_cnt_w(input int halfbit);
    return $clog2(halfbit) + 1;
  endfunction
endpackage

// File: rtl/encoder_manch_if.sv
// encoder_manch_if: byte handshake in, Manchester line and status out
interface encoder_manch_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       data_manch;
  logic       busy;
  modport master (output tx_data, tx_valid, input tx_ready, data_manch, busy);
  modport slave (input tx_data, tx_valid, output tx_ready, data_manch, busy);
endinterface

// File: rtl/manch_halfbit_timer.sv
// manch_halfbit_timer: one-cycle tick every HALFBIT clocks while enabled, restartable
module manch_halfbit_timer
  import manch_pkg::*;
#(
  parameter int HALFBIT = 81
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);
  localparam int CW = halfbit_cnt_w(HALFBIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && (cnt_q == CW'(HALFBIT - 1));
  always_comb cnt_d = (restart_i || !en_i || tick_o) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/encoder_manch.sv
// encoder_manch: byte-to-Manchester framer (preamble, sync, LSB-first data, idle gap)
module encoder_manch
  import manch_pkg::*;
#(
  parameter int CLK_FREQ      = 18_750_000,
  parameter int BAUDRATE      = 115200 * 2,
  parameter int PREAMBLE_BITS = 4,
  parameter int GAP_HALFBITS  = 4
) (
  input  logic clk,
  input  logic rst,
  encoder_manch_if.slave bus
);
  localparam int HALFBIT = halfbit_clks(CLK_FREQ, BAUDRATE);
  localparam int MAXC_PD = PREAMBLE_BITS > 8 ? PREAMBLE_BITS : 8;
  localparam int MAXC    = MAXC_PD > GAP_HALFBITS ? MAXC_PD : GAP_HALFBITS;
  localparam int BW      = $clog2(MAXC) + 1;

  if (HALFBIT < 2 || PREAMBLE_BITS < 1) begin : g_param_err
    $error("encoder_manch: HALFBIT must be >= 2 and PREAMBLE_BITS >= 1");
  end

  state_e        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          half_q, half_d, line_q, line_d, busy_q, busy_d, rdy_q, rdy_d;
  logic          tick, accept, last, cur;

  assign accept = bus.tx_valid && rdy_q;

  manch_halfbit_timer #(.HALFBIT(HALFBIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != IDLE),
    .restart_i (accept),
    .tick_o    (tick)
  );

  assign cur  = state_q == PREAMBLE ? 1'b1 : state_q == DATA ? sh_q[0] : 1'b0;
  assign last = state_q == SYNC || bit_q == (state_q == PREAMBLE ? BW'(PREAMBLE_BITS - 1) :
                                             state_q == DATA     ? BW'(7) : BW'(GAP_HALFBITS - 1));

  // Line values are chosen one cycle ahead so data_manch stays a plain register.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    half_d  = half_q;
    line_d  = line_q;
    busy_d  = busy_q;
    if (accept) begin
      state_d = PREAMBLE;
      bit_d   = '0;
      sh_d    = bus.tx_data;
      half_d  = 1'b0;
      line_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (state_q == GAP) begin
      if (tick) begin
        state_d = last ? IDLE : GAP;
        bit_d   = last ? '0 : bit_q + BW'(1);
        busy_d  = !last;
      end
    end else if (tick && !half_q) begin
      half_d = 1'b1;
      line_d = cur;
    end else if (tick) begin
      half_d = 1'b0;
      bit_d  = last ? '0 : bit_q + BW'(1);
      if (state_q == PREAMBLE) begin
        state_d = last ? SYNC : PREAMBLE;
        line_d  = last;
      end else if (state_q == SYNC) begin
        state_d = DATA;
        line_d  = ~sh_q[0];
      end else begin
        sh_d    = sh_q >> 1;
        state_d = !last ? DATA : GAP_HALFBITS == 0 ? IDLE : GAP;
        line_d  = last ? 1'b0 : ~sh_q[1];
        busy_d  = !last || GAP_HALFBITS != 0;
      end
    end
    rdy_d = state_d == IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      half_q  <= 1'b0;
      line_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      half_q  <= half_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end

  assign bus.tx_ready   = rdy_q;
  assign bus.data_manch = line_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/encoder_manch.md
ENCODER_MANCH -- requirements
Module: encoder_manch

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 18_750_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200*2, half-bit rate in Hz; HALFBIT = CLK_FREQ/BAUDRATE clocks per half-bit (default 81).
REQ-003 SHALL have parameter PREAMBLE_BITS, default 4, number of '1' bits sent before the sync bit.
REQ-004 SHALL have parameter GAP_HALFBITS, default 4, idle-low half-bits forced after each frame.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tx_data  input  8  byte to transmit, sampled on acceptance.
REQ-008 tx_valid  input  1  byte available.
REQ-009 tx_ready  output  1  encoder can accept a byte this cycle.
REQ-010 data_manch  output  1  registered Manchester serial line.
REQ-011 busy  output  1  high from acceptance until GAP completes.

Function
REQ-012 Acceptance SHALL occur on a rising clk edge where tx_valid && tx_ready; tx_data SHALL be latched into an 8-bit shift register then.
REQ-013 tx_ready SHALL be high only in IDLE; tx_valid while not ready SHALL be ignored with no side effects.
REQ-014 Encoding: bit '1' = low half then high half; bit '0' = high half then low half (mid-bit rising edge = 1, falling edge = 0).
REQ-015 Frame order: PREAMBLE_BITS '1' bits, one '0' sync bit, then tx_data LSB first (8 bits), then GAP.
REQ-016 State machine: IDLE -> PREAMBLE (on acceptance) -> SYNC (after PREAMBLE_BITS bits) -> DATA (after 1 bit) -> GAP (after 8 bits) -> IDLE (after GAP_HALFBITS half-bits).
REQ-017 First half of the first preamble bit SHALL appear on data_manch the cycle after acceptance (latency 1 clock).
REQ-018 Each half-bit SHALL last exactly HALFBIT clocks; half-bit counter width = $clog2(HALFBIT)+1, wraps to 0 at HALFBIT-1.
REQ-019 Bit counter SHALL count 0..PREAMBLE_BITS-1 in PREAMBLE and 0..7 in DATA, resetting on each state entry.
REQ-020 data_manch SHALL be 0 in IDLE and GAP.
REQ-021 Total frame SHALL be (PREAMBLE_BITS+9)*2*HALFBIT + GAP_HALFBITS*HALFBIT clocks from first preamble cycle to tx_ready high.
REQ-022 tx_ready SHALL rise the cycle IDLE is re-entered; a byte held valid is accepted that cycle (back-to-back frames separated only by GAP).
REQ-023 tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-024 HALFBIT < 2 or PREAMBLE_BITS < 1 SHALL be a elaboration-time error.

Reset
REQ-025 rst high SHALL immediately force state IDLE, data_manch 0, busy 0, tx_ready 0, counters and shift register 0, independent of clk.
REQ-026 tx_ready SHALL go high on the first clk edge after rst deasserts.
REQ-027 Reset mid-frame SHALL abort the frame; no remaining bits SHALL be emitted after release.

Structure
REQ-028 Package manch_pkg SHALL hold the state enum (IDLE, PREAMBLE, SYNC, DATA, GAP) and the HALFBIT/counter-width calculation, shared with the Manchester receiver.
REQ-029 One sub-module manch_halfbit_timer SHALL generate a one-cycle half-bit tick, restartable by the FSM on acceptance.

Verification
REQ-030 Defaults, send 0xA5 -> after 1 clk: 4 bits '1' (low/high), sync '0' (high/low), then bits 1,0,1,0,0,1,0,1; each half 81 clks; 324 clks low gap; tx_ready high at clk 2431 after acceptance.
REQ-031 tx_valid held high with 0x3C then 0xC3 -> two frames, exactly 324 low clocks between last half of first frame and first preamble half of second.
REQ-032 tx_valid pulsed with 0xFF mid-DATA of a 0x00 frame -> ignored, 0x00 frame unchanged, tx_ready low throughout.
REQ-033 rst asserted asynchronously between clk edges during DATA bit 3 -> data_manch 0 and busy 0 before next clk edge; tx_ready 1 one clk after release; line stays 0.
REQ-034 HALFBIT=2 override, send 0x01 -> cycle-exact waveform 0011 x4, 1100, 0011, 1100 x7, 00000000.
REQ-035 tx_data changed to 0x00 one clk after accepting 0xFF -> all 8 data bits still encode '1'.
